loop_sequencer: RTL and testbench
=================================

LOOP_SEQUENCER -- requirements
Module: loop_sequencer

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter CNT_W, default 8: loop-count width, matching the datapath word.
REQ-003 Port clk  input  1: sole clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1: asynchronous, active-low reset.
REQ-005 Port start  input  1: request to begin a loop; sampled only in IDLE.
REQ-006 Port count_in  input  CNT_W: iteration count, latched on an accepted start.
REQ-007 Port step_ack  input  1: datapath has completed one loop-body iteration.
REQ-008 Port abort  input  1: terminate the current loop early.
REQ-009 Port step_req  output  1: request to the datapath to execute one loop body.
REQ-010 Port busy  output  1: high in every state except IDLE.
REQ-011 Port count  output  CNT_W: remaining-iteration register.
REQ-012 Port zero  output  1: combinational zero flag of count.
REQ-013 Port done  output  1: one-cycle completion pulse.
REQ-014 Port aborted  output  1: qualifies done; high only when the loop ended by abort.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, CHECK, STEP and DONE.
REQ-016 In IDLE, start=1 at an edge SHALL load count<=count_in and move to CHECK.
REQ-017 In CHECK, zero=1 SHALL move to DONE; zero=0 SHALL move to STEP.
REQ-018 In STEP, step_req SHALL be held high until step_ack=1 is sampled.
REQ-019 On that step_ack edge: count<=count-1, move to CHECK, step_req low in CHECK.
REQ-020 In DONE, done=1 for exactly one cycle, then IDLE unconditionally.
REQ-021 Outcome: count_in=N gives exactly N step handshakes; N=0 gives none.
REQ-022 Latency for N=0: start at edge k gives CHECK in cycle k+1 and done in cycle k+2.
REQ-023 Latency for N>0: done follows the Nth step_ack by 2 cycles (CHECK, then DONE).
REQ-024 Decrement SHALL occur only when count is non-zero; count never wraps.
REQ-025 count_in=2^CNT_W-1 SHALL give 255 steps for CNT_W=8.
REQ-026 start while busy SHALL be ignored, with no effect on count or state.
REQ-027 step_ack outside STEP SHALL be ignored.
REQ-028 abort in CHECK or STEP SHALL move to DONE next edge with aborted=1 during DONE.
REQ-029 abort has priority over step_ack in the same cycle; count is not decremented.
REQ-030 abort in IDLE or DONE SHALL be ignored.
REQ-031 aborted=0 whenever done=0; count holds its value through DONE and IDLE.

Reset
REQ-032 rst_n low SHALL force IDLE and count=0, asynchronously.
REQ-033 While rst_n is low: step_req=0, busy=0, done=0, aborted=0, zero=1.
REQ-034 Reset mid-loop SHALL abandon the loop with no done pulse.
REQ-035 Release of rst_n SHALL be synchronised externally; no start is accepted in the release cycle.

Structure
REQ-036 Shared package loop_seq_pkg SHALL hold the state enum and the default CNT_W constant.
REQ-037 zero SHALL come from one instance of the datapath's existing zero-detector module on count.
REQ-038 The FSM SHALL be a single registered process; no other sub-modules.

Verification
REQ-039 count_in=3 with step_ack one cycle after each step_req: 3 handshakes, count 3->2->1->0, one done, aborted=0.
REQ-040 count_in=0: no step_req, done exactly 2 cycles after start edge, busy high for 2 cycles.
REQ-041 count_in=5, abort in 2nd STEP together with step_ack: count stays 4, done=1 and aborted=1 next cycle.
REQ-042 count_in=2, start re-pulsed with count_in=9 mid-loop: still exactly 2 steps; step_ack pulsed in CHECK ignored.
REQ-043 count_in=255 with random step_ack delays of 0-5 cycles: 255 steps, no wrap, single done.
REQ-044 rst_n low asynchronously during STEP with count=7: outputs at reset values immediately, no done after release.

Source files
------------

// File: rtl/loop_seq_pkg.sv
// Shared definitions for the loop sequencer: FSM state encoding and the default
// loop-count width.
package loop_seq_pkg;

  localparam int unsigned CNT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    STEP  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/loop_sequencer_zero_det.sv
// Datapath zero detector: flags an all-zero word combinationally.
module loop_sequencer_zero_det #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] value,
  output logic         zero
);

  assign zero = (value == '0);

endmodule

// File: rtl/loop_sequencer.sv
// Loop sequencer: counts down a latched iteration count, handshaking one
// loop-body step per iteration with the datapath, with early abort.
module loop_sequencer
  import loop_seq_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] count_in,
  input  logic             step_ack,
  input  logic             abort,
  output logic             step_req,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             zero,
  output logic             done,
  output logic             aborted
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             abort_flag, abort_flag_nxt;

  loop_sequencer_zero_det #(.W(CNT_W)) u_zero_det (
    .value (count),
    .zero  (zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      abort_flag <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      abort_flag <= abort_flag_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    count_nxt      = count;
    abort_flag_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          count_nxt = count_in;
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (abort) begin
          abort_flag_nxt = 1'b1;
          state_nxt      = DONE;
        end else if (zero) begin
          state_nxt = DONE;
        end else begin
          state_nxt = STEP;
        end
      end
      STEP: begin
        // abort wins over a simultaneous step_ack: the step is not counted
        if (abort) begin
          abort_flag_nxt = 1'b1;
          state_nxt      = DONE;
        end else if (step_ack) begin
          if (!zero) count_nxt = count - CNT_ONE;
          state_nxt = CHECK;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign step_req = (state == STEP);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign aborted  = (state == DONE) && abort_flag;

endmodule

// File: tb/tb_loop_sequencer.sv
// Self-checking bench for loop_sequencer with randomized handshake timing.
module tb_loop_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] count_in;
  logic       step_ack;
  logic       abort;
  logic       step_req;
  logic       busy;
  logic [7:0] count;
  logic       zero;
  logic       done;
  logic       aborted;

  int checks = 0;
  int errors = 0;
  logic [7:0] seen_counts[$];

  loop_sequencer #(.CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .count_in (count_in),
    .step_ack (step_ack),
    .abort    (abort),
    .step_req (step_req),
    .busy     (busy),
    .count    (count),
    .zero     (zero),
    .done     (done),
    .aborted  (aborted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [7:0] n);
    count_in = n;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Plays the datapath side of a running loop and records what it observes.
  // abort_at = k raises abort together with the k-th step_ack (0 = never).
  task automatic serve(input int dmin, input int dmax, input int abort_at,
                       input bit noise, output int steps, output int dones,
                       output int lat, output logic ab, output logic [7:0] fin);
    int dly;
    int since;
    dly = -1; since = 1; steps = 0; dones = 0; lat = -1; ab = 1'b0; fin = count;
    seen_counts.delete();
    for (int c = 0; c < 8000; c++) begin
      if (done) begin
        dones = 1; lat = since; ab = aborted; fin = count;
        break;
      end
      start = 1'b0; step_ack = 1'b0; abort = 1'b0; count_in = 8'($urandom);
      if (step_req) begin
        if (dly < 0) dly = int'($urandom_range(dmax, dmin));
        if (dly == 0) begin
          step_ack = 1'b1;
          dly = -1;
          since = 0;
          if (steps + 1 == abort_at) abort = 1'b1;
          else begin
            seen_counts.push_back(count);
            steps++;
          end
        end else dly--;
      end else if (noise) begin
        start    = 1'($urandom_range(1, 0));
        step_ack = 1'($urandom_range(1, 0));
        count_in = 8'd9;
      end
      tick();
      since++;
    end
    start = 1'b0; step_ack = 1'b0; abort = 1'b0;
  endtask

  // Reference: a run of n iterations, optionally aborted on attempt abort_at.
  task automatic check_run(input string name, input int n, input int abort_at,
                           input int steps, input int dones, input int lat,
                           input logic ab, input logic [7:0] fin);
    int   exp_steps;
    logic exp_ab;
    exp_ab    = (abort_at > 0 && abort_at <= n);
    exp_steps = exp_ab ? abort_at - 1 : n;
    checks++;
    if (dones !== 1) begin
      errors++; $display("FAIL %s done_seen: got %0d want 1", name, dones);
    end
    checks++;
    if (steps !== exp_steps) begin
      errors++; $display("FAIL %s steps: got %0d want %0d", name, steps, exp_steps);
    end
    checks++;
    if (lat !== (exp_ab ? 1 : 2)) begin
      errors++; $display("FAIL %s done_latency: got %0d want %0d", name, lat, exp_ab ? 1 : 2);
    end
    checks++;
    if (ab !== exp_ab) begin
      errors++; $display("FAIL %s aborted: got %0b want %0b", name, ab, exp_ab);
    end
    checks++;
    if (fin !== 8'(n - exp_steps)) begin
      errors++; $display("FAIL %s final_count: got %0d want %0d", name, fin, n - exp_steps);
    end
    for (int i = 0; i < seen_counts.size() && i < exp_steps; i++) begin
      checks++;
      if (seen_counts[i] !== 8'(n - i)) begin
        errors++; $display("FAIL %s count_at_step%0d: got %0d want %0d", name, i, seen_counts[i], n - i);
      end
    end
    tick();
    checks++;
    if (done !== 1'b0 || aborted !== 1'b0 || busy !== 1'b0 || count !== fin) begin
      errors++;
      $display("FAIL %s after_done: got done=%0b aborted=%0b busy=%0b count=%0d want 0 0 0 %0d",
               name, done, aborted, busy, count, fin);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; count_in = '0; step_ack = 1'b0; abort = 1'b0;
    tick();
    checks++;
    if ({step_req, busy, done, aborted, zero} !== 5'b00001 || count !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%0b busy=%0b done=%0b ab=%0b zero=%0b count=%0d want 0 0 0 0 1 0",
               step_req, busy, done, aborted, zero, count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_three_steps();
    int s, d, l; logic a; logic [7:0] f;
    launch(8'd3);
    serve(1, 1, 0, 1'b0, s, d, l, a, f);
    check_run("three_steps", 3, 0, s, d, l, a, f);
  endtask

  task automatic test_zero_count();
    launch(8'd0);
    checks++;
    if (busy !== 1'b1 || step_req !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL zero_check_cycle: got busy=%0b req=%0b done=%0b want 1 0 0", busy, step_req, done);
    end
    tick();
    checks++;
    if (busy !== 1'b1 || done !== 1'b1 || aborted !== 1'b0 || step_req !== 1'b0) begin
      errors++; $display("FAIL zero_done_cycle: got busy=%0b done=%0b ab=%0b req=%0b want 1 1 0 0", busy, done, aborted, step_req);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL zero_idle: got busy=%0b done=%0b want 0 0", busy, done);
    end
  endtask

  task automatic test_abort_with_ack();
    int s, d, l; logic a; logic [7:0] f;
    launch(8'd5);
    serve(0, 2, 2, 1'b0, s, d, l, a, f);
    check_run("abort_step2", 5, 2, s, d, l, a, f);
  endtask

  task automatic test_abort_idle_check();
    abort = 1'b1;
    tick(); tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_idle: got busy=%0b done=%0b want 0 0", busy, done);
    end
    launch(8'd4);
    tick();
    checks++;
    if (done !== 1'b1 || aborted !== 1'b1 || count !== 8'd4) begin
      errors++; $display("FAIL abort_check: got done=%0b ab=%0b count=%0d want 1 1 4", done, aborted, count);
    end
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0 || count !== 8'd4) begin
      errors++; $display("FAIL abort_in_done: got busy=%0b done=%0b ab=%0b count=%0d want 0 0 0 4", busy, done, aborted, count);
    end
  endtask

  task automatic test_restart_ignored();
    int s, d, l; logic a; logic [7:0] f;
    launch(8'd2);
    serve(0, 3, 0, 1'b1, s, d, l, a, f);
    check_run("restart_ignored", 2, 0, s, d, l, a, f);
  endtask

  task automatic test_random_loops();
    int s, d, l, n, ab_at; logic a; logic [7:0] f;
    for (int r = 0; r < 6; r++) begin
      n     = int'($urandom_range(12, 1));
      ab_at = ($urandom_range(2, 0) == 0) ? int'($urandom_range(n, 1)) : 0;
      launch(8'(n));
      serve(0, 4, ab_at, 1'b1, s, d, l, a, f);
      check_run("random_loop", n, ab_at, s, d, l, a, f);
    end
  endtask

  task automatic test_max_count();
    int s, d, l; logic a; logic [7:0] f;
    launch(8'd255);
    serve(0, 5, 0, 1'b0, s, d, l, a, f);
    check_run("max_count", 255, 0, s, d, l, a, f);
  endtask

  task automatic test_async_reset();
    int guard;
    int late_done;
    launch(8'd7);
    guard = 0;
    while (!step_req && guard < 10) begin tick(); guard++; end
    checks++;
    if (step_req !== 1'b1 || count !== 8'd7) begin
      errors++; $display("FAIL reset_setup: got req=%0b count=%0d want 1 7", step_req, count);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({step_req, busy, done, aborted, zero} !== 5'b00001 || count !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: got req=%0b busy=%0b done=%0b ab=%0b zero=%0b count=%0d want 0 0 0 0 1 0",
               step_req, busy, done, aborted, zero, count);
    end
    tick(); tick();
    @(negedge clk);
    rst_n = 1'b1;
    late_done = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done || busy) late_done++;
    end
    checks++;
    if (late_done !== 0) begin
      errors++; $display("FAIL reset_no_done: got %0d active cycles want 0", late_done);
    end
  endtask

  initial begin
    test_reset();
    test_three_steps();
    test_zero_count();
    test_abort_with_ack();
    test_abort_idle_check();
    test_restart_ignored();
    test_random_loops();
    test_max_count();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
